// File: rtl/bcd_pkg.sv
// Shared types and constants for the packed-BCD arithmetic blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bcd_pkg;

  localparam int BCD_W       = 4;
  localparam int NDIGITS_DEF = 100;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_sub.sv
// One BCD digit subtract cell: d = a - b - bin with decimal borrow.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             bin,
  output logic [BCD_W-1:0] d,
  output logic             bout,
  output logic             invalid
);

  // 5-bit two's-complement difference covers -16..15, so bit 4 is the sign.
  logic [BCD_W:0] t;

  // Binary subtract, then add ten back when the digit went negative.
  always_comb begin
    t       = {1'b0, a} - {1'b0, b} - {{BCD_W{1'b0}}, bin};
    bout    = t[BCD_W];
    d       = t[BCD_W] ? (t[BCD_W-1:0] + 4'd10) : t[BCD_W-1:0];
    invalid = (a > 4'd9) | (b > 4'd9);
  end

endmodule

// File: rtl/bcd_sub100_serial.sv
// Digit-serial packed-BCD subtractor, diff = a - b - bin, LSD first, one digit per clock.
// Latency: NDIGITS+1 cycles from accepted start to the done pulse.
// Backpressure: start is ignored while busy; results are held until the next accepted start.
module bcd_sub100_serial
  import bcd_pkg::*;
#(
  parameter int NDIGITS = NDIGITS_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [BCD_W*NDIGITS-1:0] a,
  input  logic [BCD_W*NDIGITS-1:0] b,
  input  logic                     bin,
  output logic                     busy,
  output logic                     done,
  output logic [BCD_W*NDIGITS-1:0] diff,
  output logic                     bout,
  output logic                     err
);

  localparam int W  = BCD_W * NDIGITS;
  localparam int CW = $clog2(NDIGITS);
  localparam logic [CW-1:0] LAST = CW'(NDIGITS - 1);

  state_t      state;
  logic [W-1:0] a_sr;
  logic [W-1:0] b_sr;
  logic [W-1:0] diff_sr;
  logic [CW-1:0] count;
  logic        borrow;

  bcd_digit_t  dig_d;
  logic        dig_bout;
  logic        dig_inv;

  bcd_digit_sub u_digit (
    .a       (a_sr[BCD_W-1:0]),
    .b       (b_sr[BCD_W-1:0]),
    .bin     (borrow),
    .d       (dig_d),
    .bout    (dig_bout),
    .invalid (dig_inv)
  );

  // Control FSM, operand/result shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
      err     <= 1'b0;
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      count   <= '0;
      borrow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // diff and bout stay visible from the previous result until the next done.
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= bin;
            count  <= '0;
            err    <= 1'b0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sr    <= a_sr >> BCD_W;
          b_sr    <= b_sr >> BCD_W;
          diff_sr <= {dig_d, diff_sr[W-1:BCD_W]};
          borrow  <= dig_bout;
          err     <= err | dig_inv;
          count   <= count + 1'b1;
          if (count == LAST) begin
            // Last digit goes straight into the output register alongside the shifted-in ones.
            diff  <= {dig_d, diff_sr[W-1:BCD_W]};
            bout  <= dig_bout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_sub100_serial.sv
// Self-checking bench for bcd_sub100_serial: directed cases plus random BCD operands.
// Reference: nines-complement decimal addition over digit arrays.
// Timing: inputs driven and outputs sampled 1 ns after the rising edge.
module tb_bcd_sub100_serial;

  localparam int N = 100;
  localparam int W = 4 * N;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         err;

  int errors = 0;
  int checks = 0;
  int busy_bad = 0;

  bcd_sub100_serial #(.NDIGITS(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // a - b - bin == a + (10^N - 1 - b) + (1 - bin) - 10^N; no final carry means underflow.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                                output logic [W-1:0] md, output logic mbo);
    int c;
    int s;
    c  = mbin ? 0 : 1;
    md = '0;
    for (int i = 0; i < N; i++) begin
      s = int'(ma[4*i +: 4]) + 9 - int'(mb[4*i +: 4]) + c;
      md[4*i +: 4] = 4'(s % 10);
      c = s / 10;
    end
    mbo = (c == 0);
  endfunction

  function automatic logic [W-1:0] rand_bcd(input int ndig);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < ndig; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
    a     = ta;
    b     = tb;
    bin   = tbin;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Steps until done (bounded), checking busy on every cycle before it.
  task automatic wait_done(input int from_cyc, output int lat);
    int cyc;
    cyc = from_cyc;
    while (!done && cyc < from_cyc + 300) begin
      if (!busy) busy_bad++;
      step();
      cyc++;
    end
    lat = cyc;
    check("done_seen", W'(done), W'(1));
    check("busy_in_done", W'(busy), W'(0));
  endtask

  logic [W-1:0] ea, eb, ed, r1;
  logic         ebin, ebo, r1bo;
  int           lat;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    #1;
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_diff", diff, '0);
    check("rst_bout", W'(bout), W'(0));
    check("rst_err",  W'(err),  W'(0));
    #13;
    rst_n = 1'b1;
    step();
    step();
    check("idle_busy", W'(busy), W'(0));

    // 5 - 3 - 0
    start_op(W'(5), W'(3), 1'b0);
    busy_bad = 0;
    wait_done(1, lat);
    check("t1_latency", W'(lat), W'(101));
    check("t1_busy_window", W'(busy_bad), W'(0));
    check("t1_diff", diff, W'(2));
    check("t1_bout", W'(bout), W'(0));
    check("t1_err",  W'(err),  W'(0));
    step();
    check("t1_done_pulse", W'(done), W'(0));
    check("t1_diff_hold", diff, W'(2));

    // 0 - 0 - 1 wraps to all nines
    start_op('0, '0, 1'b1);
    wait_done(1, lat);
    check("t2_latency", W'(lat), W'(101));
    check("t2_diff", diff, {N{4'h9}});
    check("t2_bout", W'(bout), W'(1));

    // 10^99 - 1
    ea = '0;
    ea[4*99 +: 4] = 4'h1;
    start_op(ea, W'(1), 1'b0);
    wait_done(1, lat);
    check("t3_diff", diff, {4'h0, {(N-1){4'h9}}});
    check("t3_bout", W'(bout), W'(0));

    // Invalid digit in a: processed normally, flagged
    start_op(W'(4'hA), '0, 1'b0);
    wait_done(1, lat);
    check("t4_latency", W'(lat), W'(101));
    check("t4_err", W'(err), W'(1));
    check("t4_diff", diff, W'(4'hA));
    check("t4_bout", W'(bout), W'(0));

    // Random operands, some short so that a < b or equal lengths occur
    for (int k = 0; k < 6; k++) begin
      ea   = rand_bcd((k % 2 == 0) ? N : $urandom_range(1, N));
      eb   = rand_bcd((k % 3 == 0) ? N : $urandom_range(1, N));
      ebin = 1'($urandom_range(0, 1));
      model(ea, eb, ebin, ed, ebo);
      start_op(ea, eb, ebin);
      busy_bad = 0;
      wait_done(1, lat);
      check("rnd_latency", W'(lat), W'(101));
      check("rnd_busy_window", W'(busy_bad), W'(0));
      check("rnd_diff", diff, ed);
      check("rnd_bout", W'(bout), W'(ebo));
      check("rnd_err", W'(err), W'(0));
    end

    // start during busy is ignored; start in DONE cycle chains immediately
    ea   = rand_bcd(N);
    eb   = rand_bcd(N);
    ebin = 1'b0;
    model(ea, eb, ebin, r1, r1bo);
    start_op(ea, eb, ebin);
    for (int i = 1; i < 50; i++) step();
    a     = rand_bcd(N);
    b     = rand_bcd(N);
    bin   = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("ign_busy", W'(busy), W'(1));
    wait_done(51, lat);
    check("ign_latency", W'(lat), W'(101));
    check("ign_diff", diff, r1);
    check("ign_bout", W'(bout), W'(r1bo));
    ea   = rand_bcd(N);
    eb   = rand_bcd(N);
    ebin = 1'b1;
    model(ea, eb, ebin, ed, ebo);
    start_op(ea, eb, ebin);
    check("b2b_busy", W'(busy), W'(1));
    check("b2b_diff_hold", diff, r1);
    wait_done(102, lat);
    check("b2b_latency", W'(lat), W'(202));
    check("b2b_diff", diff, ed);
    check("b2b_bout", W'(bout), W'(ebo));

    // Asynchronous reset mid-operation
    start_op({N{4'h9}}, W'(1), 1'b0);
    for (int i = 1; i < 40; i++) step();
    rst_n = 1'b0;
    #1;
    check("mrst_busy", W'(busy), W'(0));
    check("mrst_done", W'(done), W'(0));
    check("mrst_diff", diff, '0);
    check("mrst_bout", W'(bout), W'(0));
    check("mrst_err",  W'(err),  W'(0));
    #3;
    rst_n = 1'b1;
    step();
    ea   = rand_bcd(N);
    eb   = rand_bcd(N);
    ebin = 1'b0;
    model(ea, eb, ebin, ed, ebo);
    start_op(ea, eb, ebin);
    wait_done(1, lat);
    check("post_rst_latency", W'(lat), W'(101));
    check("post_rst_diff", diff, ed);
    check("post_rst_bout", W'(bout), W'(ebo));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
